prio_arb_enc: RTL and testbench
===============================

# prio_arb_enc

Parametrised, registered N-input priority encoder and arbiter. It succeeds the team's 3-input combinational priority encoder, which maps input a→3, b→2, c→1 and none→0. It adds configurable width, a round-robin mode, a one-hot grant and a hold-until-acknowledge handshake. It sits between a set of requesters and a shared resource, and its binary code output stays drop-in compatible with the old 2-bit q.

## Interface
- N, default 3: number of requesters, legal range 2..32.
- CW, default $clog2(N+1): code width, derived and not overridden. N=3 gives CW=2.
- clk, input, 1: sole clock, rising edge.
- rst_n, input, 1: reset, synchronous and active-low. It is sampled only on the rising edge of clk.
- req, input, N: request vector. Bit N-1 is top priority in fixed mode.
- mode, input, 1: arbitration mode. 0 = fixed priority, 1 = round-robin. It is sampled only when an arbitration occurs.
- ack, input, 1: consumer accepts the current grant. It is ignored while gnt_vld=0.
- gnt, output, N: one-hot grant, registered.
- code, output, CW: index of the granted requester plus 1, registered. 0 means no grant.
- gnt_vld, output, 1: a grant is held, registered. It equals |gnt.

## Operation
- **States:**
  - IDLE: no grant held.
  - GRANT: one grant held.
- **Pointer:** p is a log2(N)-bit register holding the top-priority index.
  - Fixed mode uses N-1 as the search start. p is left unchanged in fixed mode.
  - Round-robin mode uses p as the search start.
- **Arbitration:** search req downward from the start index, wrapping from 0 to N-1. The first set bit is the winner w.
  - The registered result is gnt=1<<w and code=w+1.
  - If no bit is set, the result is gnt=0 and code=0.
- **IDLE:**
  - If |req, arbitrate and go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT, hold:** when ack=0 and req[w]=1, outputs hold unchanged.
  - New higher-priority requests do not preempt the grant.
  - A mode change while in GRANT has no effect until the next arbitration.
- **GRANT, ack=1:** the grant is released.
  - In round-robin mode, p ← (w==0) ? N-1 : w-1.
  - Then arbitrate on the current req, using the updated start index. Go to GRANT if any request remains, else IDLE.
  - A still-asserted req[w] is a new request.
- **GRANT, withdrawal (ack=0, req[w]=0):** the grant is released and p is unchanged.
  - Arbitrate on the current req. Go to GRANT or IDLE as above.
- **ack with withdrawal in the same cycle:** treated as an ack, so the pointer advances.
- **Code equivalence:** in fixed mode with N=3 and req={a,b,c}, code equals the old q on the cycle after sampling.

## Timing
- **Reset:** rst_n=0 at a rising edge sets:
  - state=IDLE, p=N-1;
  - gnt=0, code=0, gnt_vld=0.
  - This applies in every state, including mid-grant. No ack is implied and there is no pointer advance beyond the reset value.
- **First grant after reset:** the first edge with rst_n=1 may arbitrate, so outputs are valid one cycle after release.
- **Request-to-grant latency:** 1 cycle. A req sampled at edge t appears on gnt/code/gnt_vld after edge t.
- **Ack-to-next-grant latency:** 1 cycle. Back-to-back grants are possible with no idle bubble.
- **Throughput:** one grant per cycle, when ack is asserted every cycle.
- **Combinational paths:** none from inputs to outputs. All outputs come straight from flops.

## Structure
- **Package prio_arb_pkg holds:**
  - the state enum {IDLE, GRANT};
  - the mode constants MODE_FIXED=0 and MODE_RR=1;
  - the clog2 helper used for CW and the pointer width.
- **Sub-module prio_find_first (combinational):**
  - Inputs: req[N-1:0] and start index s.
  - Outputs: found and idx. idx is the first set bit scanning downward from s with wrap-around.
  - It is instantiated once and feeds the registered outputs and the pointer update.
- **Top level:** contains only the state, pointer and output registers plus the next-state logic.

## Test plan
All scenarios use N=3.
1. **Reset:** hold rst_n=0 for 2 cycles with req=111 → gnt=000, code=00, gnt_vld=0. The first cycle after release gives code=11 and gnt=100.
2. **Legacy truth table:** mode=0, apply all 8 values of req, acking each → code is 11 for req 1xx, 10 for 01x, 01 for 001, and 00 with gnt_vld=0 for 000.
3. **Hold:** mode=0, req=001 → code=01. Then raise req to 111 with ack=0 for 5 cycles → code stays 01. Pulse ack → code=11 on the next cycle.
4. **Round-robin rotation:** mode=1, req=111 constant, ack=1 every cycle → code sequence 11, 10, 01, 11, 10, with no idle cycle.
5. **Withdrawal:** mode=1, req=101, grant at code=11. Drop req to 001 with no ack → next cycle code=01. p is still 2, so a later req=111 after ack is granted index 0's successor per p=2→2-1... the ack of index 0 sets p=2, giving code=11.
6. **Reset mid-grant:** mode=1 with code=10 held. Assert rst_n=0 for one edge → all outputs are 0. After release with req=111 → code=11, because p has returned to 2.

Source files
------------

// File: rtl/prio_arb_pkg.sv
// Shared types, constants and width helper for the priority arbiter/encoder.
package prio_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Ceiling log2 for elaboration-time widths. The operand is kept small
   // (N+1 <= 33), so the shift never reaches the int sign bit.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/prio_arb_enc_find_first.sv
// Wrap-around downward search: first set request bit at or below start s.
module prio_find_first
   import prio_arb_pkg::*;
#(
   parameter int N  = 3,
   parameter int PW = clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] s,
   output logic          found,
   output logic [PW-1:0] idx
);

   int            sj;
   logic [PW-1:0] j;

   // Scan s, s-1, ..., 0, N-1, ... and latch the first hit.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      sj    = 0;
      j     = '0;
      for (int i = 0; i < N; i++) begin
         sj = int'(s) - i;
         if (sj < 0) sj = sj + N;
         j = PW'(sj);
         if (!found && req[j]) begin
            found = 1'b1;
            idx   = j;
         end
      end
   end

endmodule

// File: rtl/prio_arb_enc.sv
// Registered N-input priority encoder / arbiter with fixed and round-robin
// modes, one-hot grant, binary code (index+1) and hold-until-ack handshake.
module prio_arb_enc
   import prio_arb_pkg::*;
#(
   parameter  int N  = 3,
   localparam int CW = clog2(N + 1),
   localparam int PW = clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   input  logic          mode,
   input  logic          ack,
   output logic [N-1:0]  gnt,
   output logic [CW-1:0] code,
   output logic          gnt_vld
);

   localparam logic [PW-1:0] TOP = PW'(N - 1);

   state_e        state_q, state_d;
   logic [PW-1:0] p_q, p_d;
   logic [N-1:0]  gnt_q, gnt_d;
   logic [CW-1:0] code_q, code_d;
   logic          vld_q, vld_d;

   logic [CW-1:0] code_m1;
   logic [PW-1:0] w;
   logic [PW-1:0] p_adv;
   logic [PW-1:0] p_next;
   logic [PW-1:0] start;
   logic          hold;
   logic          arb;
   logic          found;
   logic [PW-1:0] idx;

   prio_find_first #(.N(N), .PW(PW)) u_find (
      .req   (req),
      .s     (start),
      .found (found),
      .idx   (idx)
   );

   // Release decision, pointer update and arbitration result.
   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      gnt_d   = gnt_q;
      code_d  = code_q;
      vld_d   = vld_q;

      // Held winner index recovered from the registered code.
      code_m1 = code_q - CW'(1);
      w       = code_m1[PW-1:0];
      p_adv   = (w == '0) ? TOP : w - PW'(1);

      // Grant is kept only while unacked and its request is still up.
      hold = (state_q == GRANT) && !ack && |(gnt_q & req);
      arb  = !hold;

      // An ack (even alongside withdrawal) rotates the pointer in RR mode.
      p_next = ((state_q == GRANT) && ack && (mode == MODE_RR)) ? p_adv : p_q;
      start  = (mode == MODE_RR) ? p_next : TOP;

      if (arb) begin
         p_d = p_next;
         if (found) begin
            state_d = GRANT;
            gnt_d   = {{(N-1){1'b0}}, 1'b1} << idx;
            code_d  = CW'(idx) + CW'(1);
            vld_d   = 1'b1;
         end else begin
            state_d = IDLE;
            gnt_d   = '0;
            code_d  = '0;
            vld_d   = 1'b0;
         end
      end
   end

   // State, pointer and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         p_q     <= TOP;
         gnt_q   <= '0;
         code_q  <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         gnt_q   <= gnt_d;
         code_q  <= code_d;
         vld_q   <= vld_d;
      end
   end

   assign gnt     = gnt_q;
   assign code    = code_q;
   assign gnt_vld = vld_q;

endmodule

// File: tb/tb_prio_arb_enc.sv
// Scoreboard bench for prio_arb_enc (N=3): stimulus queues hand-computed
// expectations tagged with the cycle they apply to; a monitor checks them.
module tb_prio_arb_enc;

   logic       clk;
   logic       rst_n;
   logic [2:0] req;
   logic       mode;
   logic       ack;
   logic [2:0] gnt;
   logic [1:0] code;
   logic       gnt_vld;

   int tests;
   int fails;
   int cyc;

   typedef struct {
      int         cyc;
      logic [2:0] gnt;
      logic [1:0] code;
      logic       vld;
      string      name;
   } exp_t;

   exp_t sb[$];

   prio_arb_enc #(.N(3)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .mode    (mode),
      .ack     (ack),
      .gnt     (gnt),
      .code    (code),
      .gnt_vld (gnt_vld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Apply inputs for the next edge and queue the outputs expected after it.
   task automatic drive(input logic [2:0] r, input logic m, input logic a,
                        input logic rn, input logic [2:0] eg,
                        input logic [1:0] ec, input string nm);
      exp_t e;
      @(negedge clk);
      req   = r;
      mode  = m;
      ack   = a;
      rst_n = rn;
      e.cyc  = cyc + 1;
      e.gnt  = eg;
      e.code = ec;
      e.vld  = (eg != 3'b000);
      e.name = nm;
      sb.push_back(e);
   endtask

   // Monitor: compare every expectation whose cycle has arrived.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            tests++;
            if (e.cyc != cyc || gnt !== e.gnt || code !== e.code || gnt_vld !== e.vld) begin
               fails++;
               $display("FAIL %s @cyc%0d: got gnt=%b code=%b vld=%b, want gnt=%b code=%b vld=%b",
                        e.name, cyc, gnt, code, gnt_vld, e.gnt, e.code, e.vld);
            end
         end
      end
   end

   logic [2:0] leg_req  [8];
   logic [2:0] leg_gnt  [8];
   logic [1:0] leg_code [8];

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      req   = 3'b000;
      mode  = 1'b0;
      ack   = 1'b0;

      leg_req  = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
      leg_gnt  = '{3'b000, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
      leg_code = '{2'b00,  2'b01,  2'b10,  2'b10,  2'b11,  2'b11,  2'b11,  2'b11};

      // 1. reset held two edges with requests pending, then first grant
      drive(3'b111, 0, 0, 0, 3'b000, 2'b00, "rst0");
      drive(3'b111, 0, 0, 0, 3'b000, 2'b00, "rst1");
      drive(3'b111, 0, 0, 1, 3'b100, 2'b11, "first_grant");

      // 2. legacy truth table in fixed mode, acking each
      for (int i = 0; i < 8; i++)
         drive(leg_req[i], 0, 1, 1, leg_gnt[i], leg_code[i], $sformatf("legacy_%b", leg_req[i]));

      // 3. hold: higher requests do not preempt until ack
      drive(3'b001, 0, 1, 1, 3'b001, 2'b01, "hold_start");
      for (int i = 0; i < 5; i++)
         drive(3'b111, 0, 0, 1, 3'b001, 2'b01, $sformatf("hold_%0d", i));
      drive(3'b111, 0, 1, 1, 3'b100, 2'b11, "hold_ack");
      drive(3'b000, 0, 1, 1, 3'b000, 2'b00, "to_idle");

      // 4. round-robin rotation, no idle bubble (p still 2 from reset)
      drive(3'b111, 1, 1, 1, 3'b100, 2'b11, "rr0");
      drive(3'b111, 1, 1, 1, 3'b010, 2'b10, "rr1");
      drive(3'b111, 1, 1, 1, 3'b001, 2'b01, "rr2");
      drive(3'b111, 1, 1, 1, 3'b100, 2'b11, "rr3");
      drive(3'b111, 1, 1, 1, 3'b010, 2'b10, "rr4");

      // 6. reset mid-grant returns pointer to top
      drive(3'b111, 1, 0, 1, 3'b010, 2'b10, "mid_hold");
      drive(3'b111, 1, 0, 0, 3'b000, 2'b00, "mid_rst");
      drive(3'b111, 1, 0, 1, 3'b100, 2'b11, "post_rst");

      // 5. withdrawal keeps pointer; later ack of index 0 wraps p to 2
      drive(3'b000, 1, 0, 1, 3'b000, 2'b00, "wd_idle");
      drive(3'b101, 1, 0, 1, 3'b100, 2'b11, "wd_grant");
      drive(3'b001, 1, 0, 1, 3'b001, 2'b01, "wd_drop");
      drive(3'b111, 1, 1, 1, 3'b100, 2'b11, "wd_ack_wrap");

      // ack together with withdrawal advances pointer (p=2, w=1 -> p=0)
      drive(3'b000, 1, 0, 1, 3'b000, 2'b00, "aw_idle");
      drive(3'b011, 1, 0, 1, 3'b010, 2'b10, "aw_grant");
      drive(3'b101, 1, 1, 1, 3'b001, 2'b01, "aw_ack_wd");
      drive(3'b000, 1, 1, 1, 3'b000, 2'b00, "aw_end");

      // mode change during a held grant has no effect until next arbitration
      drive(3'b010, 0, 0, 1, 3'b010, 2'b10, "mc_grant");
      drive(3'b011, 1, 0, 1, 3'b010, 2'b10, "mc_hold");

      // drain the scoreboard within a bounded number of cycles
      for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
      @(negedge clk);
      if (sb.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d expectations unchecked, want 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
